// File: rtl/alu_seq_divider_pkg.sv
// alu_seq_divider_pkg: shared op codes, state encoding and width for the sequential divider
package alu_seq_divider_pkg;
  localparam int WIDTH = 8;
  localparam logic [2:0] OP_PASS   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_ADDC   = 3'b011;
  localparam logic [2:0] OP_ADDNOT = 3'b100;
  localparam logic [2:0] OP_SUB    = 3'b101;
  localparam logic [2:0] OP_DEC    = 3'b110;
  localparam logic [2:0] OP_PASS2  = 3'b111;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: restoring divider sequencing subtracts through the external arithmetic unit
module alu_seq_divider
  import alu_seq_divider_pkg::*;
#(
  parameter int WIDTH = alu_seq_divider_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       alu_sel,
  output logic             alu_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] p, q, d, s, p_nxt;
  logic [CW-1:0] cnt;
  logic ge;
  assign s = {p[WIDTH-2:0], q[WIDTH-1]};
  // the bit shifted out of P makes S+256 exceed D, so the subtract is always taken
  assign ge = p[WIDTH-1] | (s >= d);
  assign p_nxt = ge ? alu_y : s;
  always_comb begin
    {alu_sel, alu_cin} = (state == DIV) ? OP_SUB : OP_PASS;
    alu_a = (state == DIV) ? s : '0;
    alu_b = (state == DIV) ? d : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      p <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            state <= DONE;
            done <= 1'b1;
            quotient <= '1;
            remainder <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= DIV;
            busy <= 1'b1;
            d <= divisor;
            q <= dividend;
            p <= '0;
            cnt <= '0;
            div_by_zero <= 1'b0;
          end
        end
        DIV: begin
          p <= p_nxt;
          q <= {q[WIDTH-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            quotient <= {q[WIDTH-2:0], ge};
            remainder <= p_nxt;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_divider.sv
// tb_alu_seq_divider: scoreboard bench for alu_seq_divider with a behavioural arithmetic unit
module tb_alu_seq_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero, alu_cin;
  logic [7:0] quotient, remainder, alu_a, alu_b, alu_y;
  logic [1:0] alu_sel;
  typedef struct {
    logic [7:0] a, b, q, r;
    logic dz;
    int lat, t0;
  } exp_t;
  exp_t sb[$];
  int cyc = 0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .alu_sel(alu_sel), .alu_cin(alu_cin),
    .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
  );
  // arithmetic unit: A + {0, B, ~B, FF} selected by alu_sel, plus carry-in
  assign alu_y = alu_a + (alu_sel[1] ? (alu_sel[0] ? 8'hFF : ~alu_b)
                                     : (alu_sel[0] ? alu_b : 8'h00)) + {7'b0, alu_cin};
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (busy) chk("alu_op_in_div", {alu_sel, alu_cin}, 3'b101);
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.dz);
        chk("latency", cyc - e.t0, e.lat);
        chk("busy_at_done", busy, 0);
        if (!e.dz) begin
          chk("invariant", int'(quotient) * int'(e.b) + int'(remainder), e.a);
          chk("rem_lt_div", int'(remainder < e.b), 1);
        end
      end
    end
  end
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                      input logic [7:0] r, input logic dz);
    exp_t e;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dz = dz; e.lat = dz ? 1 : 9; e.t0 = cyc;
    sb.push_back(e);
    dividend = a;
    divisor = b;
    start = 1'b1;
  endtask
  task automatic wait_done();
    int k = 0;
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                     input logic [7:0] r, input logic dz);
    push(a, b, q, r, dz);
    @(negedge clk);
    start = 1'b0;
    if (dz) chk("busy_dz", busy, 0);
    wait_done();
  endtask
  task automatic chk_idle(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_q"}, quotient, 0);
    chk({name, "_r"}, remainder, 0);
    chk({name, "_dz"}, div_by_zero, 0);
    chk({name, "_alu"}, {alu_sel, alu_cin, alu_a, alu_b}, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);
    run(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    run(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    run(8'd255, 8'd128, 8'd1, 8'd127, 1'b0);
    run(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    run(8'd128, 8'd255, 8'd0, 8'd128, 1'b0);
    run(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    run(8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
    run(8'd10, 8'd3, 8'd3, 8'd1, 1'b0);
    push(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    repeat (3) @(negedge clk);
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (12) @(negedge clk);
    chk("quotient_held", quotient, 14);
    dividend = 8'd100;
    divisor = 8'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle("midreset");
    repeat (12) @(negedge clk);
    chk("midreset_no_done", busy | done, 0);
    run(8'd9, 8'd2, 8'd4, 8'd1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      run(a, b, a / b, a % b, 1'b0);
    end
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/alu_seq_divider.md
Name: alu_seq_divider

Overview:
- Multi-cycle 8-bit unsigned restoring divider that acts as the initiator on the team's 8-bit arithmetic-unit interface.
- Drives the op select, carry-in, A and B operands, and consumes the returned 8-bit result.
- Sits beside the existing arithmetic unit (ALU_arith) in the datapath. It owns the sequencing; the unit stays purely combinational.
- One subtract per quotient bit: 8 iterations per division.

Parameters:
- WIDTH, 8, operand/result width; must match the arithmetic unit width. Only 8 is verified.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- dividend  in  8  numerator, captured on accepted start
- divisor  in  8  denominator, captured on accepted start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse; results valid from this cycle until the next accepted start
- quotient  out  8  result
- remainder  out  8  result
- div_by_zero  out  1  set with done when divisor==0; cleared on next accepted start
- alu_sel  out  2  op select to arithmetic unit
- alu_cin  out  1  carry-in to arithmetic unit
- alu_a  out  8  operand A
- alu_b  out  8  operand B
- alu_y  in  8  combinational result from arithmetic unit (same cycle)

Behaviour:
Reset:
- rst_n sampled low at clk edge forces state IDLE.
- busy=0, done=0, div_by_zero=0, quotient=0, remainder=0.
- Internal P (partial remainder), Q, D and count are cleared.
- Applies mid-division too: the operation is abandoned and done is not raised.

State IDLE:
- alu_sel=00, alu_cin=0, alu_a=0, alu_b=0 (pass-A code, benign).
- On start=1 with divisor!=0:
  - capture D=divisor, Q=dividend, P=0, count=0;
  - clear div_by_zero;
  - go to DIV; busy=1 next cycle.
- On start=1 with divisor==0:
  - go to DONE;
  - quotient=8'hFF, remainder=dividend, div_by_zero=1.

State DIV (exactly 8 cycles, count 0..7):
- S = {P[6:0],Q[7]}, shifted partial remainder; carry-out bit c = P[7].
- Drive alu_sel=10, alu_cin=1 (A-B code), alu_a=S, alu_b=D.
- ge = c | (S >= D), local 8-bit compare; no borrow is taken from the ALU.
- At clock edge:
  - if ge: P <= alu_y (mod-256 result is exact because the true difference is < 256); else P <= S;
  - Q <= {Q[6:0], ge};
  - count++.
- After count==7 go to DONE.

State DONE (one cycle):
- done=1, busy=0.
- quotient <= Q, remainder <= P (registered at entry, so valid when done is high).
- Return to IDLE next cycle.

Latency and handshake:
- Accepted start at edge N: busy high N+1..N+8, done high at N+9.
- Divide-by-zero: done at N+1; busy never rises.
- start while busy or done is ignored; no queueing.
- start held high re-triggers on the first IDLE cycle after done.

Other rules:
- quotient/remainder hold their values between operations. They are not cleared on start, only on reset.
- Invariant on completion (divisor!=0): quotient*divisor + remainder == dividend, remainder < divisor.

Decomposition:
- Shared package holds:
  - ALU op codes as 3-bit {sel,cin} constants: OP_PASS=000, OP_INC=001, OP_ADD=010, OP_ADDC=011, OP_ADDNOT=100, OP_SUB=101, OP_DEC=110, OP_PASS2=111;
  - state encoding IDLE/DIV/DONE;
  - WIDTH.
- No internal sub-module. The arithmetic unit (ALU_arith) is instantiated by the parent and wired to the alu_* ports. The bench instantiates both.

Test Plan:
- Nominal: start with dividend=100, divisor=7 -> done at N+9, quotient=14, remainder=2, div_by_zero=0; alu_sel/alu_cin = 10/1 on all 8 busy cycles.
- Edge values:
  - 255/1 -> q=255, r=0;
  - 255/128 -> q=1, r=127;
  - 5/9 -> q=0, r=5;
  - 128/255 -> q=0, r=128 (checks the c=P[7] path).
- Divide by zero: 200/0 -> done at N+1, busy never 1, q=8'hFF, r=200, div_by_zero=1. A following 10/3 clears div_by_zero and gives q=3, r=1.
- Ignored start: pulse start with 50/5 at N+3 during a 100/7 divide -> 100/7 results unaffected, no second done.
- Reset mid-op: rst_n low at N+4 -> next cycle state IDLE, all outputs 0, no done pulse. Restart with 9/2 -> q=4, r=1.
- Random: 1000 random pairs with divisor!=0 against a reference model. Check the invariant and the exact 9-cycle latency.
